// File: rtl/sqrt_job_sequencer_pkg.sv
// sqrt_seq_pkg
// Shared definitions for the square-root job sequencer: the controller
// state enum and the default data-memory map / timing constants that the
// top level uses as parameter defaults.
// No ports (package).

package sqrt_seq_pkg;

    // Controller states, in the order a normal job walks through them.
    typedef enum logic [3:0] {
        IDLE,
        LOAD_HI,
        LOAD_LO,
        START_HOLD,
        RESET_HOLD,
        RUN,
        READ,
        CAPTURE,
        FINISH
    } seq_state_e;

    // Default data-memory layout of the square-root program.
    localparam int DEF_OPND_ADDR = 16;
    localparam int DEF_RES_ADDR  = 18;

    // Default CPU handshake timing.
    localparam int DEF_START_CYC = 2;
    localparam int DEF_RST_CYC   = 2;
    localparam int DEF_TIMEOUT   = 65535;

endpackage

// File: rtl/sqrt_job_sequencer_if.sv
// sqrt_job_sequencer_if
// Bundles every non-clock signal of the job sequencer: the host job
// handshake, the sequencer's data-memory port and the CPU control lines.
// Modports:
//   master - environment side (host, data memory, CPU): drives JobReq,
//            JobOperand, DmRdData, CpuAck.
//   slave  - sequencer side: drives JobBusy, JobDone, JobResult,
//            JobTimeout, DmOwner, DmWrEn, DmAddr, DmWrData, CpuReset,
//            CpuStart.

interface sqrt_job_sequencer_if;

    logic        JobReq;
    logic [15:0] JobOperand;
    logic        JobBusy;
    logic        JobDone;
    logic [7:0]  JobResult;
    logic        JobTimeout;
    logic        DmOwner;
    logic        DmWrEn;
    logic [7:0]  DmAddr;
    logic [7:0]  DmWrData;
    logic [7:0]  DmRdData;
    logic        CpuReset;
    logic        CpuStart;
    logic        CpuAck;

    modport master (
        output JobReq, JobOperand, DmRdData, CpuAck,
        input  JobBusy, JobDone, JobResult, JobTimeout,
        input  DmOwner, DmWrEn, DmAddr, DmWrData, CpuReset, CpuStart
    );

    modport slave (
        input  JobReq, JobOperand, DmRdData, CpuAck,
        output JobBusy, JobDone, JobResult, JobTimeout,
        output DmOwner, DmWrEn, DmAddr, DmWrData, CpuReset, CpuStart
    );

endinterface

// File: rtl/sqrt_job_sequencer_counter.sv
// seq_cycle_counter
// Loadable up/down cycle counter with a terminal flag. The sequencer
// shares one instance between the START_HOLD and RESET_HOLD delays
// (loaded with N-1, counting down to zero) and the RUN timeout (loaded
// with zero, counting up to the last allowed cycle).
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   load       - load load_val this cycle (has priority over en)
//   en         - count one step this cycle
//   up         - count direction, 1 = increment, 0 = decrement
//   load_val   - value taken on load
//   term_val   - value that raises terminal
//   terminal   - current count equals term_val

module seq_cycle_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term_val,
    output logic             terminal
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: a load wins over counting so a phase change can
    // re-arm the counter in the same cycle the previous phase ends.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = up ? count_q + 1'b1 : count_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal = (count_q == term_val);

endmodule

// File: rtl/sqrt_job_sequencer.sv
// sqrt_job_sequencer
// Runs the square-root program on the CPU for one host job at a time:
// writes the 16-bit operand into data memory (high byte at OPND_ADDR, low
// byte at OPND_ADDR+1), pulses CpuStart then releases CpuReset, waits for
// CpuAck (bounded by TIMEOUT cycles), reads the 8-bit result from
// RES_ADDR and returns it with a one-cycle JobDone.
// Ports:
//   Clk, Reset - clock and synchronous active-high reset
//   bus        - sqrt_job_sequencer_if.slave (job handshake, DM port,
//                CPU control); every output is registered
// Optional build macro:
//   ZERO_BYPASS_EN - a zero operand finishes immediately with result 0,
//                    without touching data memory or the CPU.

module sqrt_job_sequencer
    import sqrt_seq_pkg::*;
#(
    parameter int OPND_ADDR = DEF_OPND_ADDR,
    parameter int RES_ADDR  = DEF_RES_ADDR,
    parameter int START_CYC = DEF_START_CYC,
    parameter int RST_CYC   = DEF_RST_CYC,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                 Clk,
    input  logic                 Reset,
    sqrt_job_sequencer_if.slave  bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [7:0]       OPND_HI_ADDR = 8'(OPND_ADDR);
    localparam logic [7:0]       OPND_LO_ADDR = 8'(OPND_ADDR + 1);
    localparam logic [7:0]       RESULT_ADDR  = 8'(RES_ADDR);
    localparam logic [CNT_W-1:0] START_LOAD   = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] RUN_LAST     = CNT_W'(TIMEOUT - 1);

    seq_state_e  state_q, state_d;
    logic [15:0] operand_q, operand_d;
    logic        job_busy_q, job_busy_d;
    logic        job_done_q, job_done_d;
    logic [7:0]  job_result_q, job_result_d;
    logic        job_timeout_q, job_timeout_d;
    logic        dm_owner_q, dm_owner_d;
    logic        dm_wr_en_q, dm_wr_en_d;
    logic [7:0]  dm_addr_q, dm_addr_d;
    logic [7:0]  dm_wr_data_q, dm_wr_data_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        cpu_start_q, cpu_start_d;

    logic             cnt_load;
    logic             cnt_en;
    logic             cnt_up;
    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] cnt_term_val;
    logic             cnt_terminal;

    // The RUN phase watches for the last permitted cycle; the hold phases
    // watch for the counter reaching zero.
    assign cnt_term_val = (state_q == RUN) ? RUN_LAST : '0;

    seq_cycle_counter #(
        .WIDTH (CNT_W)
    ) u_cycle_counter (
        .clk      (Clk),
        .rst      (Reset),
        .load     (cnt_load),
        .en       (cnt_en),
        .up       (cnt_up),
        .load_val (cnt_load_val),
        .term_val (cnt_term_val),
        .terminal (cnt_terminal)
    );

    // Next state, captured job data, and counter control. The output
    // values are then derived from the state being entered so that every
    // output register already shows the new state's values in its first
    // cycle.
    always_comb begin
        state_d       = state_q;
        operand_d     = operand_q;
        job_result_d  = job_result_q;
        job_timeout_d = job_timeout_q;
        cnt_load      = 1'b0;
        cnt_en        = 1'b0;
        cnt_up        = 1'b0;
        cnt_load_val  = '0;

        case (state_q)
            IDLE: begin
                if (bus.JobReq) begin
                    operand_d     = bus.JobOperand;
                    job_timeout_d = 1'b0;
`ifdef ZERO_BYPASS_EN
                    if (bus.JobOperand == 16'd0) begin
                        job_result_d = '0;
                        state_d      = FINISH;
                    end else begin
                        state_d = LOAD_HI;
                    end
`else
                    state_d = LOAD_HI;
`endif
                end
            end
            LOAD_HI: begin
                state_d = LOAD_LO;
            end
            LOAD_LO: begin
                state_d      = START_HOLD;
                cnt_load     = 1'b1;
                cnt_load_val = START_LOAD;
            end
            START_HOLD: begin
                if (cnt_terminal) begin
                    state_d      = RESET_HOLD;
                    cnt_load     = 1'b1;
                    cnt_load_val = RST_LOAD;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            RESET_HOLD: begin
                if (cnt_terminal) begin
                    state_d      = RUN;
                    cnt_load     = 1'b1;
                    cnt_load_val = '0;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            RUN: begin
                cnt_en = 1'b1;
                cnt_up = 1'b1;
                // An Ack in the last permitted cycle still completes normally.
                if (bus.CpuAck) begin
                    state_d = READ;
                end else if (cnt_terminal) begin
                    state_d       = FINISH;
                    job_timeout_d = 1'b1;
                    job_result_d  = '0;
                end
            end
            READ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // Read data for the address presented in READ arrives now.
                job_result_d = bus.DmRdData;
                state_d      = FINISH;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        job_busy_d   = (state_d != IDLE);
        job_done_d   = (state_d == FINISH);
        dm_owner_d   = (state_d != RUN);
        cpu_reset_d  = (state_d != RUN);
        dm_wr_en_d   = (state_d == LOAD_HI) || (state_d == LOAD_LO);
        cpu_start_d  = (state_d == LOAD_HI) || (state_d == LOAD_LO) ||
                       (state_d == START_HOLD);
        dm_addr_d    = dm_addr_q;
        dm_wr_data_d = dm_wr_data_q;

        case (state_d)
            LOAD_HI: begin
                dm_addr_d    = OPND_HI_ADDR;
                dm_wr_data_d = operand_d[15:8];
            end
            LOAD_LO: begin
                dm_addr_d    = OPND_LO_ADDR;
                dm_wr_data_d = operand_d[7:0];
            end
            READ: begin
                dm_addr_d = RESULT_ADDR;
            end
            default: begin
            end
        endcase
    end

    // State and output registers; reset leaves the CPU held in reset and
    // the data-memory port owned by the sequencer.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            operand_q     <= '0;
            job_busy_q    <= 1'b0;
            job_done_q    <= 1'b0;
            job_result_q  <= '0;
            job_timeout_q <= 1'b0;
            dm_owner_q    <= 1'b1;
            dm_wr_en_q    <= 1'b0;
            dm_addr_q     <= '0;
            dm_wr_data_q  <= '0;
            cpu_reset_q   <= 1'b1;
            cpu_start_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            operand_q     <= operand_d;
            job_busy_q    <= job_busy_d;
            job_done_q    <= job_done_d;
            job_result_q  <= job_result_d;
            job_timeout_q <= job_timeout_d;
            dm_owner_q    <= dm_owner_d;
            dm_wr_en_q    <= dm_wr_en_d;
            dm_addr_q     <= dm_addr_d;
            dm_wr_data_q  <= dm_wr_data_d;
            cpu_reset_q   <= cpu_reset_d;
            cpu_start_q   <= cpu_start_d;
        end
    end

    assign bus.JobBusy    = job_busy_q;
    assign bus.JobDone    = job_done_q;
    assign bus.JobResult  = job_result_q;
    assign bus.JobTimeout = job_timeout_q;
    assign bus.DmOwner    = dm_owner_q;
    assign bus.DmWrEn     = dm_wr_en_q;
    assign bus.DmAddr     = dm_addr_q;
    assign bus.DmWrData   = dm_wr_data_q;
    assign bus.CpuReset   = cpu_reset_q;
    assign bus.CpuStart   = cpu_start_q;

endmodule
